// File: rtl/s298_chk_pkg.sv
// Shared types and constants for the S298 golden-vs-netlist response checker.
package s298_chk_pkg;

   localparam int unsigned CHK_WIDTH    = 6;
   localparam int unsigned CHK_CNT_W    = 16;
   localparam int unsigned SETTLE_W     = 4;
   // MISR feedback taps are sig[WIDTH-1] and sig[WIDTH-MISR_TAP_OFS]
   localparam int unsigned MISR_TAP_OFS = 2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RUN    = 2'd2,
      ST_HALT   = 2'd3
   } chk_state_e;

endpackage

// File: rtl/s298_response_checker_sat_counter.sv
// Saturating up-counter with enable and synchronous active-high reset.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q, count_d;

   // Increment while enabled, sticking at all-ones
   always_comb begin
      count_d = count_q;
      if (en && (count_q != {W{1'b1}})) count_d = count_q + W'(1);
   end

   // Count register
   always_ff @(posedge clk) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/s298_response_checker.sv
// S298 response checker: compares golden and netlist output vectors every
// RUN cycle, counts mismatches and keeps sticky first-failure information.
// Optional MISR over the golden stream is built when S298_CHK_MISR_EN is
// defined; otherwise signature is tied to zero.
module s298_response_checker
   import s298_chk_pkg::*;
#(
   parameter int unsigned WIDTH        = CHK_WIDTH,
   parameter int unsigned SETTLE       = 2,
   parameter int unsigned CNT_W        = CHK_CNT_W,
   parameter int unsigned STOP_ON_FAIL = 0
) (
   input  logic             Clock,
   input  logic             reset,
   input  logic             compare_en,
   input  logic [WIDTH-1:0] golden,
   input  logic [WIDTH-1:0] dut,
   output logic             busy,
   output logic             mismatch,
   output logic             fail,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] first_fail_cycle,
   output logic [WIDTH-1:0] first_fail_diff,
   output logic [WIDTH-1:0] signature
);

   chk_state_e          state_q, state_d;
   logic [SETTLE_W-1:0] settle_q, settle_d;
   logic                busy_q, busy_d;
   logic                mismatch_q, mismatch_d;
   logic                fail_q, fail_d;
   logic [CNT_W-1:0]    ffc_q, ffc_d;
   logic [WIDTH-1:0]    ffd_q, ffd_d;
   logic [WIDTH-1:0]    diff_c;
   logic                diff_nz_c;
   logic                run_cmp_c;

   // Vector difference; X/Z bits are flagged as mismatches in simulation
   always_comb begin
      diff_c = golden ^ dut;
`ifndef SYNTHESIS
      diff_nz_c = (golden !== dut);
`else
      diff_nz_c = |diff_c;
`endif
   end

   // Next-state logic: settle window, compare window and halt-on-fail
   always_comb begin
      state_d   = state_q;
      settle_d  = settle_q;
      run_cmp_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (compare_en) begin
               if (SETTLE == 0) begin
                  state_d = ST_RUN;
               end else begin
                  state_d  = ST_SETTLE;
                  settle_d = SETTLE_W'(SETTLE);
               end
            end
         end
         ST_SETTLE: begin
            if (!compare_en) begin
               state_d  = ST_IDLE;
               settle_d = '0;
            end else begin
               settle_d = settle_q - SETTLE_W'(1);
               if (settle_q <= SETTLE_W'(1)) state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!compare_en) begin
               state_d = ST_IDLE;
            end else begin
               run_cmp_c = 1'b1;
               if (diff_nz_c && (STOP_ON_FAIL != 0)) state_d = ST_HALT;
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d  = ST_IDLE;
            settle_d = '0;
         end
      endcase
   end

   // Next values of the status outputs and first-failure capture
   always_comb begin
      busy_d     = (state_d == ST_SETTLE) || (state_d == ST_RUN);
      mismatch_d = run_cmp_c && diff_nz_c;
      fail_d     = fail_q || mismatch_d;
      ffc_d      = ffc_q;
      ffd_d      = ffd_q;
      if (mismatch_d && !fail_q) begin
         ffc_d = cycle_count;
         ffd_d = diff_c;
      end
   end

   // State and status registers
   always_ff @(posedge Clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         settle_q   <= '0;
         busy_q     <= 1'b0;
         mismatch_q <= 1'b0;
         fail_q     <= 1'b0;
         ffc_q      <= '0;
         ffd_q      <= '0;
      end else begin
         state_q    <= state_d;
         settle_q   <= settle_d;
         busy_q     <= busy_d;
         mismatch_q <= mismatch_d;
         fail_q     <= fail_d;
         ffc_q      <= ffc_d;
         ffd_q      <= ffd_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_err_cnt (
      .clk   (Clock),
      .reset (reset),
      .en    (mismatch_d),
      .count (err_count)
   );

   sat_counter #(.W(CNT_W)) u_cycle_cnt (
      .clk   (Clock),
      .reset (reset),
      .en    (run_cmp_c),
      .count (cycle_count)
   );

`ifdef S298_CHK_MISR_EN
   logic [WIDTH-1:0] sig_q, sig_d;

   // MISR compacts the golden stream only on compared cycles
   always_comb begin
      sig_d = sig_q;
      if (run_cmp_c)
         sig_d = {sig_q[WIDTH-2:0], sig_q[WIDTH-1] ^ sig_q[WIDTH-MISR_TAP_OFS]} ^ golden;
   end

   // Signature register
   always_ff @(posedge Clock) begin
      if (reset) sig_q <= '0;
      else       sig_q <= sig_d;
   end

   assign signature = sig_q;
`else
   assign signature = '0;
`endif

   assign busy             = busy_q;
   assign mismatch         = mismatch_q;
   assign fail             = fail_q;
   assign first_fail_cycle = ffc_q;
   assign first_fail_diff  = ffd_q;

endmodule

// File: tb/tb_s298_response_checker.sv
// Bench for s298_response_checker: three configurations share one stimulus
// stream (SETTLE=2; SETTLE=2 with STOP_ON_FAIL; SETTLE=0 with 4-bit counters).
module tb_s298_response_checker;

   localparam int NI = 3;

   logic       Clock = 1'b0;
   logic       reset, compare_en;
   logic [5:0] golden, dut;

   logic        busy0, mm0, fail0, busy1, mm1, fail1, busy2, mm2, fail2;
   logic [15:0] err0, cyc0, ffc0, err1, cyc1, ffc1;
   logic [3:0]  err2, cyc2, ffc2;
   logic [5:0]  ffd0, sig0, ffd1, sig1, ffd2, sig2;

   always #5 Clock = ~Clock;

   s298_response_checker #(.WIDTH(6), .SETTLE(2), .CNT_W(16), .STOP_ON_FAIL(0)) u_dut0 (
      .Clock(Clock), .reset(reset), .compare_en(compare_en), .golden(golden), .dut(dut),
      .busy(busy0), .mismatch(mm0), .fail(fail0), .err_count(err0), .cycle_count(cyc0),
      .first_fail_cycle(ffc0), .first_fail_diff(ffd0), .signature(sig0));

   s298_response_checker #(.WIDTH(6), .SETTLE(2), .CNT_W(16), .STOP_ON_FAIL(1)) u_dut1 (
      .Clock(Clock), .reset(reset), .compare_en(compare_en), .golden(golden), .dut(dut),
      .busy(busy1), .mismatch(mm1), .fail(fail1), .err_count(err1), .cycle_count(cyc1),
      .first_fail_cycle(ffc1), .first_fail_diff(ffd1), .signature(sig1));

   s298_response_checker #(.WIDTH(6), .SETTLE(0), .CNT_W(4), .STOP_ON_FAIL(0)) u_dut2 (
      .Clock(Clock), .reset(reset), .compare_en(compare_en), .golden(golden), .dut(dut),
      .busy(busy2), .mismatch(mm2), .fail(fail2), .err_count(err2), .cycle_count(cyc2),
      .first_fail_cycle(ffc2), .first_fail_diff(ffd2), .signature(sig2));

   logic        o_busy[NI], o_mm[NI], o_fail[NI];
   logic [15:0] o_err[NI], o_cyc[NI], o_ffc[NI];
   logic [5:0]  o_ffd[NI], o_sig[NI];

   always_comb begin
      o_busy[0] = busy0; o_mm[0] = mm0; o_fail[0] = fail0;
      o_err[0] = err0; o_cyc[0] = cyc0; o_ffc[0] = ffc0; o_ffd[0] = ffd0; o_sig[0] = sig0;
      o_busy[1] = busy1; o_mm[1] = mm1; o_fail[1] = fail1;
      o_err[1] = err1; o_cyc[1] = cyc1; o_ffc[1] = ffc1; o_ffd[1] = ffd1; o_sig[1] = sig1;
      o_busy[2] = busy2; o_mm[2] = mm2; o_fail[2] = fail2;
      o_err[2] = {12'd0, err2}; o_cyc[2] = {12'd0, cyc2}; o_ffc[2] = {12'd0, ffc2};
      o_ffd[2] = ffd2; o_sig[2] = sig2;
   end

   // Reference model: a cycle is compared when compare_en has been high for
   // SETTLE+2 consecutive edges since reset or the last low, and the checker
   // has not stopped on a failure.
   int          p_settle[NI], p_stop[NI];
   logic [15:0] p_max[NI];
   int          streak[NI];
   bit          halted[NI];
   bit          m_busy[NI], m_mm[NI], m_fail[NI];
   logic [15:0] m_err[NI], m_cyc[NI], m_ffc[NI];
   logic [5:0]  m_ffd[NI], m_sig[NI];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic model_edge();
      logic [5:0] dv;
      bit cmp;
      dv = golden ^ dut;
      for (int k = 0; k < NI; k++) begin
         if (reset) begin
            streak[k] = 0; halted[k] = 0; m_busy[k] = 0; m_mm[k] = 0; m_fail[k] = 0;
            m_err[k] = '0; m_cyc[k] = '0; m_ffc[k] = '0; m_ffd[k] = '0; m_sig[k] = '0;
         end else begin
            if (!compare_en)       streak[k] = 0;
            else if (streak[k] < 1000) streak[k] = streak[k] + 1;
            cmp = compare_en && !halted[k] && (streak[k] >= p_settle[k] + 2);
            m_mm[k] = cmp && (dv != 6'd0);
            if (cmp) begin
               if (dv != 6'd0) begin
                  if (!m_fail[k]) begin
                     m_ffc[k] = m_cyc[k];
                     m_ffd[k] = dv;
                  end
                  m_fail[k] = 1;
                  if (m_err[k] < p_max[k]) m_err[k] = m_err[k] + 16'd1;
                  if (p_stop[k] != 0) halted[k] = 1;
               end
               if (m_cyc[k] < p_max[k]) m_cyc[k] = m_cyc[k] + 16'd1;
`ifdef S298_CHK_MISR_EN
               m_sig[k] = {m_sig[k][4:0], m_sig[k][5] ^ m_sig[k][4]} ^ golden;
`endif
            end
            m_busy[k] = compare_en && !halted[k];
         end
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < NI; k++) begin
         chk($sformatf("i%0d_busy", k), 16'(o_busy[k]), 16'(m_busy[k]));
         chk($sformatf("i%0d_mismatch", k), 16'(o_mm[k]), 16'(m_mm[k]));
         chk($sformatf("i%0d_fail", k), 16'(o_fail[k]), 16'(m_fail[k]));
         chk($sformatf("i%0d_err_count", k), o_err[k], m_err[k]);
         chk($sformatf("i%0d_cycle_count", k), o_cyc[k], m_cyc[k]);
         chk($sformatf("i%0d_first_fail_cycle", k), o_ffc[k], m_ffc[k]);
         chk($sformatf("i%0d_first_fail_diff", k), 16'(o_ffd[k]), 16'(m_ffd[k]));
         chk($sformatf("i%0d_signature", k), 16'(o_sig[k]), 16'(m_sig[k]));
      end
   endtask

   task automatic step(input logic r, input logic en, input logic [5:0] g, input logic [5:0] d);
      reset = r; compare_en = en; golden = g; dut = d;
      @(posedge Clock);
      model_edge();
      #1;
      check_all();
   endtask

   typedef struct {
      logic        en;
      logic [5:0]  g, d;
      logic        busy, mm, fail;
      logic [15:0] err, cyc, ffc;
      logic [5:0]  ffd;
   } vec_t;

   vec_t tbl[12];

   initial begin
      p_settle[0] = 2; p_stop[0] = 0; p_max[0] = 16'hFFFF;
      p_settle[1] = 2; p_stop[1] = 1; p_max[1] = 16'hFFFF;
      p_settle[2] = 0; p_stop[2] = 0; p_max[2] = 16'h000F;
      for (int k = 0; k < NI; k++) begin
         streak[k] = 0; halted[k] = 0;
      end

      // SETTLE=2: edge 0 leaves IDLE, edges 1-2 settle, compares start at edge 3
      tbl[0]  = '{1'b1, 6'h2A, 6'h2A, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 6'h00};
      tbl[1]  = '{1'b1, 6'h2A, 6'h2A, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 6'h00};
      tbl[2]  = '{1'b1, 6'h2A, 6'h2A, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 6'h00};
      tbl[3]  = '{1'b1, 6'h2A, 6'h2A, 1'b1, 1'b0, 1'b0, 16'd0, 16'd1, 16'd0, 6'h00};
      tbl[4]  = '{1'b1, 6'h2A, 6'h2A, 1'b1, 1'b0, 1'b0, 16'd0, 16'd2, 16'd0, 6'h00};
      tbl[5]  = '{1'b1, 6'h2A, 6'h2A, 1'b1, 1'b0, 1'b0, 16'd0, 16'd3, 16'd0, 6'h00};
      tbl[6]  = '{1'b1, 6'h2A, 6'h2A, 1'b1, 1'b0, 1'b0, 16'd0, 16'd4, 16'd0, 6'h00};
      tbl[7]  = '{1'b1, 6'h2A, 6'h2A, 1'b1, 1'b0, 1'b0, 16'd0, 16'd5, 16'd0, 6'h00};
      tbl[8]  = '{1'b1, 6'h2A, 6'h2B, 1'b1, 1'b1, 1'b1, 16'd1, 16'd6, 16'd5, 6'h01};
      tbl[9]  = '{1'b1, 6'h2A, 6'h2A, 1'b1, 1'b0, 1'b1, 16'd1, 16'd7, 16'd5, 6'h01};
      tbl[10] = '{1'b0, 6'h2A, 6'h2B, 1'b0, 1'b0, 1'b1, 16'd1, 16'd7, 16'd5, 6'h01};
      tbl[11] = '{1'b1, 6'h00, 6'h3F, 1'b1, 1'b0, 1'b1, 16'd1, 16'd7, 16'd5, 6'h01};

      // Reset held with differing vectors and compare_en high
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 6'h15, 6'h2A);
      chk("rst_busy", 16'(busy0), 16'd0);
      chk("rst_fail", 16'(fail0), 16'd0);
      chk("rst_err", err0, 16'd0);
      chk("rst_cyc", cyc0, 16'd0);

      // Table-driven directed run
      for (int i = 0; i < 12; i++) begin
         step(1'b0, tbl[i].en, tbl[i].g, tbl[i].d);
         chk($sformatf("tbl%0d_busy", i), 16'(busy0), 16'(tbl[i].busy));
         chk($sformatf("tbl%0d_mismatch", i), 16'(mm0), 16'(tbl[i].mm));
         chk($sformatf("tbl%0d_fail", i), 16'(fail0), 16'(tbl[i].fail));
         chk($sformatf("tbl%0d_err", i), err0, tbl[i].err);
         chk($sformatf("tbl%0d_cyc", i), cyc0, tbl[i].cyc);
         chk($sformatf("tbl%0d_ffc", i), ffc0, tbl[i].ffc);
         chk($sformatf("tbl%0d_ffd", i), 16'(ffd0), 16'(tbl[i].ffd));
      end

      // Stop-on-fail: two back-to-back mismatches at compare index 3
      step(1'b1, 1'b0, 6'h00, 6'h00);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 6'h11, 6'h11);
      step(1'b0, 1'b1, 6'h11, 6'h13);
      chk("halt_mm_pulse", 16'(mm1), 16'd1);
      step(1'b0, 1'b1, 6'h11, 6'h31);
      chk("halt_mm_after", 16'(mm1), 16'd0);
      for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 6'h11, 6'h11);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 6'h11, 6'h10);
      chk("halt_err", err1, 16'd1);
      chk("halt_cyc", cyc1, 16'd4);
      chk("halt_ffc", ffc1, 16'd3);
      chk("halt_ffd", 16'(ffd1), 16'h02);
      chk("halt_busy", 16'(busy1), 16'd0);

      // Saturation of 4-bit counters under continuous mismatch
      step(1'b1, 1'b0, 6'h00, 6'h00);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 6'h00, 6'h3F);
      chk("sat_err", {12'd0, err2}, 16'h000F);
      chk("sat_cyc", {12'd0, cyc2}, 16'h000F);
      chk("sat_ffc", {12'd0, ffc2}, 16'd0);

      // Reset wins over a same-cycle mismatch mid-run
      step(1'b1, 1'b1, 6'h00, 6'h3F);
      chk("rstpri_mm", 16'(mm0), 16'd0);
      chk("rstpri_fail", 16'(fail0), 16'd0);
      chk("rstpri_err", err0, 16'd0);
      chk("rstpri_busy", 16'(busy0), 16'd0);

`ifdef S298_CHK_MISR_EN
      // MISR sequence from a cleared signature
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 6'h00, 6'h00);
      step(1'b0, 1'b1, 6'h01, 6'h01);
      chk("misr_0", 16'(sig0), 16'h01);
      step(1'b0, 1'b1, 6'h02, 6'h02);
      chk("misr_1", 16'(sig0), 16'h00);
      step(1'b0, 1'b1, 6'h03, 6'h03);
      chk("misr_2", 16'(sig0), 16'h03);
`endif

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         logic       r, en;
         logic [5:0] g, d;
         r  = ($urandom_range(0, 49) == 0);
         en = ($urandom_range(0, 9) != 0);
         g  = 6'($urandom);
         d  = ($urandom_range(0, 7) == 0) ? (g ^ (6'd1 << $urandom_range(0, 5))) : g;
         step(r, en, g, d);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
